// File: rtl/control_sequencer_pkg.sv
// Shared types and codes for the hardwired fetch/execute sequencer.
// Holds the state enum, opcodes, FunSel/select/mux codes, ALU map and IDLE word.
package corg_ctrl_pkg;

    localparam int IR_W = 16;
    localparam int OP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_FETCH_L  = 3'd2,
        S_FETCH_H  = 3'd3,
        S_EXEC     = 3'd4,
        S_HALT     = 3'd5,
        S_HALT_ILL = 3'd6
    } seq_state_e;

    localparam logic [OP_W-1:0] OP_LSR = 4'h7;
    localparam logic [OP_W-1:0] OP_LD  = 4'h8;
    localparam logic [OP_W-1:0] OP_ST  = 4'h9;
    localparam logic [OP_W-1:0] OP_MVA = 4'hA;
    localparam logic [OP_W-1:0] OP_BRA = 4'hB;
    localparam logic [OP_W-1:0] OP_BEQ = 4'hC;
    localparam logic [OP_W-1:0] OP_BNE = 4'hD;
    localparam logic [OP_W-1:0] OP_ILL = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_AR = 2'b01;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    localparam logic [3:0] SEL_PC = 4'b1000;
    localparam logic [3:0] SEL_AR = 4'b0100;

    localparam logic [3:0] ALU_PASS_A = 4'h0;

    typedef struct packed {
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_r_sel;
        logic [3:0] rf_t_sel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_fun_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_word_t;

    // Everything quiet; memory chip select is active-low.
    function automatic ctrl_word_t idle_word();
        ctrl_word_t w;
        w = '0;
        w.mem_cs = 1'b1;
        return w;
    endfunction

    // Opcodes 0..7 -> ALU_System function codes.
    function automatic logic [3:0] alu_map(input logic [OP_W-1:0] op);
        logic [3:0] f;
        unique case (op[2:0])
            3'd0: f = 4'h7;
            3'd1: f = 4'h8;
            3'd2: f = 4'h9;
            3'd3: f = 4'h2;
            3'd4: f = 4'h4;
            3'd5: f = 4'h6;
            3'd6: f = 4'hB;
            default: f = 4'hC;
        endcase
        return f;
    endfunction

    // Register index 0 (R1) maps to the MSB of the select.
    function automatic logic [3:0] onehot(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and ALU_System (slave).
// Carries IROut/ALUOutFlag back to the sequencer and every control field out.
interface control_sequencer_if;
    import corg_ctrl_pkg::*;

    logic [IR_W-1:0] IROut;
    logic [3:0]      ALUOutFlag;
    logic [2:0]      RF_OutASel;
    logic [2:0]      RF_OutBSel;
    logic [1:0]      RF_FunSel;
    logic [3:0]      RF_RSel;
    logic [3:0]      RF_TSel;
    logic [3:0]      ALU_FunSel;
    logic [1:0]      ARF_OutCSel;
    logic [1:0]      ARF_OutDSel;
    logic [1:0]      ARF_FunSel;
    logic [3:0]      ARF_RegSel;
    logic            IR_LH;
    logic            IR_Enable;
    logic [1:0]      IR_Funsel;
    logic            Mem_WR;
    logic            Mem_CS;
    logic [1:0]      MuxASel;
    logic [1:0]      MuxBSel;
    logic            MuxCSel;

    modport master (
        input  IROut, ALUOutFlag,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
        output ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
        output ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
        output Mem_CS, MuxASel, MuxBSel, MuxCSel
    );

    modport slave (
        output IROut, ALUOutFlag,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
        input  ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
        input  ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
        input  Mem_CS, MuxASel, MuxBSel, MuxCSel
    );

endinterface

// File: rtl/control_sequencer_decode.sv
// Pure combinational decoder: state + IR + zero flag -> control word.
// Ports: state, ir (IROut), flag_z (ALUOutFlag Z), cw (control word out).
module ctrl_decode
    import corg_ctrl_pkg::*;
(
    input  seq_state_e      state,
    input  logic [IR_W-1:0] ir,
    input  logic            flag_z,
    output ctrl_word_t      cw
);

    logic [OP_W-1:0] op;
    logic [1:0]      rd;
    logic [1:0]      rs1;
    logic [1:0]      rs2;

    assign op  = ir[15:12];
    assign rd  = ir[11:10];
    assign rs1 = ir[9:8];
    assign rs2 = ir[7:6];

    always_comb begin
        cw = idle_word();
        unique case (state)
            S_INIT: begin
                cw.arf_fun_sel = FS_CLR;
                cw.arf_reg_sel = 4'b1111;
                cw.rf_fun_sel  = FS_CLR;
                cw.rf_r_sel    = 4'b1111;
                cw.rf_t_sel    = 4'b1111;
            end
            S_FETCH_L, S_FETCH_H: begin
                cw.arf_out_d_sel = ARF_PC;
                cw.mem_cs        = 1'b0;
                cw.ir_enable     = 1'b1;
                cw.ir_fun_sel    = FS_LOAD;
                cw.ir_lh         = (state == S_FETCH_H);
                cw.arf_fun_sel   = FS_INC;
                cw.arf_reg_sel   = SEL_PC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    (op <= OP_LSR): begin
                        cw.rf_out_a_sel = {1'b0, rs1};
                        cw.rf_out_b_sel = {1'b0, rs2};
                        cw.alu_fun_sel  = alu_map(op);
                        cw.mux_a_sel    = MUX_ALU;
                        cw.rf_fun_sel   = FS_LOAD;
                        cw.rf_r_sel     = onehot(rd);
                    end
                    (op == OP_LD): begin
                        cw.arf_out_d_sel = ARF_AR;
                        cw.mem_cs        = 1'b0;
                        cw.mux_a_sel     = MUX_MEM;
                        cw.rf_fun_sel    = FS_LOAD;
                        cw.rf_r_sel      = onehot(rd);
                    end
                    (op == OP_ST): begin
                        cw.rf_out_a_sel  = {1'b0, rs1};
                        cw.alu_fun_sel   = ALU_PASS_A;
                        cw.arf_out_d_sel = ARF_AR;
                        cw.mem_cs        = 1'b0;
                        cw.mem_wr        = 1'b1;
                    end
                    (op == OP_MVA): begin
                        cw.mux_b_sel   = MUX_IMM;
                        cw.arf_fun_sel = FS_LOAD;
                        cw.arf_reg_sel = SEL_AR;
                    end
                    ((op == OP_BRA) ||
                     (op == OP_BEQ && flag_z) ||
                     (op == OP_BNE && !flag_z)): begin
                        cw.mux_b_sel   = MUX_IMM;
                        cw.arf_fun_sel = FS_LOAD;
                        cw.arf_reg_sel = SEL_PC;
                    end
                    default: cw = idle_word();
                endcase
            end
            default: cw = idle_word();
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for ALU_System; holds the state register.
// Ports: Clock, Reset (async low), Start, bus (master), SeqT, Halted, IllegalOp.
module control_sequencer
    import corg_ctrl_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    control_sequencer_if.master bus,
    output logic [2:0]          SeqT,
    output logic                Halted,
    output logic                IllegalOp
);

    seq_state_e      state_q;
    seq_state_e      state_d;
    ctrl_word_t      cw;
    logic [OP_W-1:0] op;
    logic            unused_flags;

    assign op           = bus.IROut[15:12];
    assign unused_flags = ^bus.ALUOutFlag[2:0];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // The illegal-opcode halt is its own state, so IllegalOp needs no extra flop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_HALT, S_HALT_ILL:
                if (Start) state_d = S_INIT;
            S_INIT:    state_d = S_FETCH_L;
            S_FETCH_L: state_d = S_FETCH_H;
            S_FETCH_H: state_d = S_EXEC;
            S_EXEC: begin
                unique case (1'b1)
                    (op == OP_HLT): state_d = S_HALT;
                    (op == OP_ILL): state_d = S_HALT_ILL;
                    default:        state_d = S_FETCH_L;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state  (state_q),
        .ir     (bus.IROut),
        .flag_z (bus.ALUOutFlag[3]),
        .cw     (cw)
    );

    always_comb begin
        bus.RF_OutASel  = cw.rf_out_a_sel;
        bus.RF_OutBSel  = cw.rf_out_b_sel;
        bus.RF_FunSel   = cw.rf_fun_sel;
        bus.RF_RSel     = cw.rf_r_sel;
        bus.RF_TSel     = cw.rf_t_sel;
        bus.ALU_FunSel  = cw.alu_fun_sel;
        bus.ARF_OutCSel = cw.arf_out_c_sel;
        bus.ARF_OutDSel = cw.arf_out_d_sel;
        bus.ARF_FunSel  = cw.arf_fun_sel;
        bus.ARF_RegSel  = cw.arf_reg_sel;
        bus.IR_LH       = cw.ir_lh;
        bus.IR_Enable   = cw.ir_enable;
        bus.IR_Funsel   = cw.ir_fun_sel;
        bus.Mem_WR      = cw.mem_wr;
        bus.Mem_CS      = cw.mem_cs;
        bus.MuxASel     = cw.mux_a_sel;
        bus.MuxBSel     = cw.mux_b_sel;
        bus.MuxCSel     = cw.mux_c_sel;
        SeqT            = state_q;
        Halted          = (state_q == S_HALT) || (state_q == S_HALT_ILL);
        IllegalOp       = (state_q == S_HALT_ILL);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench: sequencer driving a behavioural ALU_System/memory model,
// results compared against an instruction-level reference machine.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] seq_t;
    logic       halted;
    logic       illegal;

    int total = 0;
    int bad = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .Start     (start),
        .bus       (bus.master),
        .SeqT      (seq_t),
        .Halted    (halted),
        .IllegalOp (illegal)
    );

    always #5 clk = ~clk;

    // ---------------- datapath environment ----------------
    logic [15:0] rf [4];
    logic [7:0]  pc, ar, sp;
    logic [15:0] ir;
    logic [7:0]  mem [256];
    logic        z_f;
    logic [15:0] out_a, out_b, alu_a, alu_y, mux_a, mux_b;
    logic [7:0]  out_c, out_d, mem_q;
    int          cs_cnt = 0;
    int          wr_cnt = 0;

    assign out_a = rf[bus.RF_OutASel[1:0]];
    assign out_b = rf[bus.RF_OutBSel[1:0]];
    assign out_c = (bus.ARF_OutCSel == 2'd0) ? pc :
                   (bus.ARF_OutCSel == 2'd1) ? ar : sp;
    assign out_d = (bus.ARF_OutDSel == 2'd0) ? pc :
                   (bus.ARF_OutDSel == 2'd1) ? ar : sp;
    assign alu_a = bus.MuxCSel ? {8'h0, out_c} : out_a;
    assign mem_q = bus.Mem_CS ? 8'h0 : mem[out_d];
    assign bus.IROut = ir;
    assign bus.ALUOutFlag = {z_f, 3'b000};

    always_comb begin
        alu_y = '0;
        case (bus.ALU_FunSel)
            4'h0: alu_y = alu_a;
            4'h2: alu_y = ~alu_a;
            4'h4: alu_y = alu_a + out_b;
            4'h6: alu_y = alu_a - out_b;
            4'h7: alu_y = alu_a & out_b;
            4'h8: alu_y = alu_a | out_b;
            4'h9: alu_y = alu_a ^ out_b;
            4'hB: alu_y = alu_a << 1;
            4'hC: alu_y = alu_a >> 1;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        case (bus.MuxASel)
            2'd0: mux_a = alu_y;
            2'd1: mux_a = {8'h0, mem_q};
            2'd2: mux_a = {8'h0, ir[7:0]};
            default: mux_a = {8'h0, out_c};
        endcase
        case (bus.MuxBSel)
            2'd0: mux_b = alu_y;
            2'd1: mux_b = {8'h0, mem_q};
            2'd2: mux_b = {8'h0, ir[7:0]};
            default: mux_b = {8'h0, out_c};
        endcase
    end

    function automatic logic [15:0] nxt(input logic [1:0] fs,
                                        input logic [15:0] v,
                                        input logic [15:0] d);
        case (fs)
            2'b00: return v - 16'd1;
            2'b01: return v + 16'd1;
            2'b10: return d;
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.RF_RSel[3-i]) rf[i] <= nxt(bus.RF_FunSel, rf[i], mux_a);
        if (bus.ARF_RegSel[3]) pc <= 8'(nxt(bus.ARF_FunSel, {8'h0, pc}, mux_b));
        if (bus.ARF_RegSel[2]) ar <= 8'(nxt(bus.ARF_FunSel, {8'h0, ar}, mux_b));
        if (bus.ARF_RegSel[1]) sp <= 8'(nxt(bus.ARF_FunSel, {8'h0, sp}, mux_b));
        if (bus.IR_Enable && bus.IR_Funsel == 2'b10) begin
            if (bus.IR_LH) ir[15:8] <= mem_q;
            else           ir[7:0]  <= mem_q;
        end
        if (!bus.Mem_CS && bus.Mem_WR) mem[out_d] <= alu_y[7:0];
        if (bus.RF_FunSel == 2'b10 && bus.MuxASel == 2'b00 && bus.RF_RSel != 4'd0)
            z_f <= (alu_y == 16'd0);
    end

    always @(negedge clk) begin
        if (!bus.Mem_CS) cs_cnt <= cs_cnt + 1;
        if (!bus.Mem_CS && bus.Mem_WR) wr_cnt <= wr_cnt + 1;
    end

    // ---------------- instruction-level reference ----------------
    logic [7:0]  rm [256];
    logic [15:0] rr [4];
    logic [7:0]  rpc, rar;
    logic        rz;

    task automatic ref_run(output int n, output bit ill);
        logic [15:0] in, a, b, y;
        logic [3:0]  op;
        logic [1:0]  rd, s1, s2;
        logic [7:0]  imm;
        rpc = 0; rar = 0; n = 0; ill = 0;
        for (int i = 0; i < 4; i++) rr[i] = 0;
        while (n < 200) begin
            in = {rm[rpc + 8'd1], rm[rpc]};
            rpc = rpc + 8'd2;
            n++;
            op = in[15:12]; rd = in[11:10]; s1 = in[9:8];
            s2 = in[7:6]; imm = in[7:0];
            a = rr[s1]; b = rr[s2];
            if (op < 4'd8) begin
                case (op)
                    4'd0: y = a & b;
                    4'd1: y = a | b;
                    4'd2: y = a ^ b;
                    4'd3: y = ~a;
                    4'd4: y = a + b;
                    4'd5: y = a - b;
                    4'd6: y = a << 1;
                    default: y = a >> 1;
                endcase
                rr[rd] = y;
                rz = (y == 0);
            end
            else if (op == 4'h8) rr[rd] = {8'h0, rm[rar]};
            else if (op == 4'h9) rm[rar] = a[7:0];
            else if (op == 4'hA) rar = imm;
            else if (op == 4'hB) rpc = imm;
            else if (op == 4'hC) begin if (rz) rpc = imm; end
            else if (op == 4'hD) begin if (!rz) rpc = imm; end
            else if (op == 4'hE) begin ill = 1; break; end
            else break;
        end
    endtask

    // ---------------- program helpers ----------------
    function automatic logic [15:0] e_r(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] s1, input logic [1:0] s2);
        return {op, rd, s1, s2, 6'b0};
    endfunction

    function automatic logic [15:0] e_i(input logic [3:0] op, input logic [7:0] imm);
        return {op, 4'b0, imm};
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        rm[a] = d;
    endtask

    task automatic put(input logic [7:0] a, input logic [15:0] w);
        poke(a, w[7:0]);
        poke(a + 8'd1, w[15:8]);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
    endtask

    // Start the machine, optionally holding Start, and count edges until Halted.
    task automatic run(input int hold, output int cyc);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        while (!halted && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.Mem_CS !== 1'b1 || bus.IR_Enable !== 1'b0 || halted !== 1'b0 ||
            illegal !== 1'b0 || bus.RF_RSel !== 4'd0 || bus.ARF_RegSel !== 4'd0) begin
            bad++;
            $display("FAIL reset_idle: cs=%b ire=%b h=%b il=%b rsel=%h regsel=%h want 1 0 0 0 0 0",
                     bus.Mem_CS, bus.IR_Enable, halted, illegal, bus.RF_RSel, bus.ARF_RegSel);
        end
        @(negedge clk) rst_n = 1'b1;
        clear_mem();
        put(8'h00, e_r(4'h4, 2'd0, 2'd1, 2'd2));
        put(8'h02, e_i(4'hF, 8'h00));
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if ({bus.ARF_FunSel, bus.ARF_RegSel, bus.RF_FunSel, bus.RF_RSel, bus.RF_TSel}
            !== {2'b11, 4'hF, 2'b11, 4'hF, 4'hF}) begin
            bad++;
            $display("FAIL init_word: got %h want %h",
                     {bus.ARF_FunSel, bus.ARF_RegSel, bus.RF_FunSel, bus.RF_RSel, bus.RF_TSel},
                     {2'b11, 4'hF, 2'b11, 4'hF, 4'hF});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.IR_Enable, bus.IR_Funsel, bus.IR_LH, bus.Mem_CS, bus.Mem_WR,
             bus.ARF_OutDSel, bus.ARF_FunSel, bus.ARF_RegSel}
            !== {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1000}) begin
            bad++;
            $display("FAIL fetch_l_word: ire=%b irf=%b lh=%b cs=%b wr=%b od=%b fs=%b rs=%b",
                     bus.IR_Enable, bus.IR_Funsel, bus.IR_LH, bus.Mem_CS, bus.Mem_WR,
                     bus.ARF_OutDSel, bus.ARF_FunSel, bus.ARF_RegSel);
        end
        @(posedge clk); #1;
        total++;
        if (bus.IR_LH !== 1'b1 || bus.IR_Enable !== 1'b1) begin
            bad++;
            $display("FAIL fetch_h_word: lh=%b ire=%b want 1 1", bus.IR_LH, bus.IR_Enable);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.Mem_CS !== 1'b1 || bus.IR_Enable !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL async_abort: cs=%b ire=%b h=%b want 1 0 0",
                     bus.Mem_CS, bus.IR_Enable, halted);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.Mem_CS !== 1'b1 || bus.IR_Enable !== 1'b0) begin
            bad++;
            $display("FAIL stay_idle: cs=%b ire=%b want 1 0", bus.Mem_CS, bus.IR_Enable);
        end
    endtask

    task automatic test_add();
        int cyc;
        clear_mem();
        put(8'h00, e_i(4'hA, 8'h80));
        put(8'h02, e_r(4'h8, 2'd1, 2'd0, 2'd0));
        put(8'h04, e_i(4'hA, 8'h81));
        put(8'h06, e_r(4'h8, 2'd2, 2'd0, 2'd0));
        put(8'h08, e_r(4'h4, 2'd0, 2'd1, 2'd2));
        put(8'h0A, e_i(4'hF, 8'h00));
        poke(8'h80, 8'd5);
        poke(8'h81, 8'd7);
        run(1, cyc);
        total++;
        if (rf[0] !== 16'd12 || pc !== 8'h0C || cyc != 20) begin
            bad++;
            $display("FAIL add: r1=%0d pc=%h cyc=%0d want 12 0c 20", rf[0], pc, cyc);
        end
    endtask

    task automatic test_alu_random();
        int  cyc, n;
        bit  ill;
        logic [7:0] a;
        for (int it = 0; it < 8; it++) begin
            clear_mem();
            for (int k = 0; k < 4; k++) begin
                poke(8'hC0 + 8'(k), 8'($urandom));
                put(8'(4 * k), e_i(4'hA, 8'hC0 + 8'(k)));
                put(8'(4 * k + 2), e_r(4'h8, 2'(k), 2'd0, 2'd0));
            end
            a = 8'h10;
            for (int k = 0; k < 6; k++) begin
                put(a, e_r(4'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom)));
                a = a + 8'd2;
            end
            put(a, e_i(4'hF, 8'h00));
            ref_run(n, ill);
            run(1, cyc);
            for (int r = 0; r < 4; r++) begin
                total++;
                if (rf[r] !== rr[r]) begin
                    bad++;
                    $display("FAIL alu_rand it%0d R%0d: got %h want %h", it, r + 1, rf[r], rr[r]);
                end
            end
            total++;
            if (cyc != 2 + 3 * n || pc !== rpc || ar !== rar) begin
                bad++;
                $display("FAIL alu_rand_seq it%0d: cyc=%0d pc=%h ar=%h want %0d %h %h",
                         it, cyc, pc, ar, 2 + 3 * n, rpc, rar);
            end
        end
    endtask

    task automatic test_mem();
        int cyc, n, w0;
        bit ill;
        clear_mem();
        put(8'h00, e_i(4'hA, 8'h20));
        put(8'h02, e_r(4'h8, 2'd3, 2'd0, 2'd0));
        put(8'h04, e_i(4'hA, 8'h21));
        put(8'h06, e_r(4'h9, 2'd0, 2'd3, 2'd0));
        put(8'h08, e_i(4'hF, 8'h00));
        poke(8'h20, 8'h3C);
        ref_run(n, ill);
        w0 = wr_cnt;
        run(1, cyc);
        @(negedge clk);
        total++;
        if (rf[3] !== 16'h003C || mem[8'h21] !== 8'h3C || mem[8'h21] !== rm[8'h21]) begin
            bad++;
            $display("FAIL ld_st: r4=%h m21=%h want 003c 3c", rf[3], mem[8'h21]);
        end
        total++;
        if (wr_cnt - w0 != 1 || cyc != 2 + 3 * n) begin
            bad++;
            $display("FAIL st_pulse: wr_cycles=%0d cyc=%0d want 1 %0d", wr_cnt - w0, cyc, 2 + 3 * n);
        end
    endtask

    task automatic test_branch();
        int cyc, n;
        bit ill;
        logic [7:0] want [3];
        want[0] = 8'h12; want[1] = 8'h32; want[2] = 8'h06;
        for (int c = 0; c < 3; c++) begin
            clear_mem();
            put(8'h10, e_i(4'hF, 8'h00));
            put(8'h30, e_i(4'hF, 8'h00));
            if (c == 0) begin
                put(8'h00, e_r(4'h5, 2'd0, 2'd0, 2'd0));
                put(8'h02, e_i(4'hC, 8'h10));
                put(8'h04, e_i(4'hF, 8'h00));
            end else if (c == 1) begin
                poke(8'h40, 8'd3);
                put(8'h00, e_i(4'hA, 8'h40));
                put(8'h02, e_r(4'h8, 2'd0, 2'd0, 2'd0));
                put(8'h04, e_r(4'h4, 2'd0, 2'd0, 2'd0));
                put(8'h06, e_i(4'hC, 8'h10));
                put(8'h08, e_i(4'hD, 8'h30));
                put(8'h0A, e_i(4'hF, 8'h00));
            end else begin
                put(8'h00, e_r(4'h5, 2'd0, 2'd0, 2'd0));
                put(8'h02, e_i(4'hD, 8'h10));
                put(8'h04, e_i(4'hF, 8'h00));
            end
            ref_run(n, ill);
            run(1, cyc);
            total++;
            if (pc !== want[c] || pc !== rpc || cyc != 2 + 3 * n) begin
                bad++;
                $display("FAIL branch case%0d: pc=%h cyc=%0d want %h %0d",
                         c, pc, cyc, want[c], 2 + 3 * n);
            end
        end
    endtask

    task automatic test_illegal();
        int cyc, c0, k;
        clear_mem();
        put(8'h00, e_i(4'hA, 8'h55));
        put(8'h02, 16'hE000);
        run(1, cyc);
        total++;
        if (halted !== 1'b1 || illegal !== 1'b1 || cyc != 8) begin
            bad++;
            $display("FAIL illegal_halt: h=%b il=%b cyc=%0d want 1 1 8", halted, illegal, cyc);
        end
        c0 = cs_cnt;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (cs_cnt != c0 || illegal !== 1'b1) begin
            bad++;
            $display("FAIL illegal_quiet: cs_cycles=%0d il=%b want 0 1", cs_cnt - c0, illegal);
        end
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (illegal !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL illegal_restart: il=%b h=%b want 0 0", illegal, halted);
        end
        @(posedge clk); #1;
        total++;
        if (pc !== 8'h00 || ar !== 8'h00) begin
            bad++;
            $display("FAIL restart_clear: pc=%h ar=%h want 00 00", pc, ar);
        end
        k = 0;
        while (!halted && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (!halted) begin
            bad++;
            $display("FAIL rehalt_timeout: h=%b want 1", halted);
        end
    endtask

    task automatic test_halt_hold();
        int cyc, c0, w0, drops;
        clear_mem();
        put(8'h00, e_i(4'hA, 8'h10));
        put(8'h02, e_r(4'h5, 2'd1, 2'd1, 2'd1));
        put(8'h04, e_i(4'hF, 8'h00));
        run(5, cyc);
        total++;
        if (halted !== 1'b1 || illegal !== 1'b0 || cyc != 11 || pc !== 8'h06) begin
            bad++;
            $display("FAIL hlt: h=%b il=%b cyc=%0d pc=%h want 1 0 11 06",
                     halted, illegal, cyc, pc);
        end
        c0 = cs_cnt;
        w0 = wr_cnt;
        drops = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (halted !== 1'b1) drops++;
        end
        total++;
        if (drops != 0 || cs_cnt != c0 || wr_cnt != w0) begin
            bad++;
            $display("FAIL hlt_steady: drops=%0d cs=%0d wr=%0d want 0 0 0",
                     drops, cs_cnt - c0, wr_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_random();
        test_mem();
        test_branch();
        test_illegal();
        test_halt_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
